// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the uart command transmitter and receiver:
//   rx_state_e  - receive frame FSM states
//   byte_idx_e  - which byte of a command word the next good frame fills
//   DATA_BITS   - data bits per frame
//   odd_par()   - parity bit that makes {data, parity} contain an odd
//                 number of ones
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rx_state_e;

    typedef enum logic {
        IDX_HIGH = 1'b0,
        IDX_LOW  = 1'b1
    } byte_idx_e;

    function automatic logic odd_par(input logic [DATA_BITS-1:0] data_byte);
        return ~^data_byte;
    endfunction

endpackage

// File: rtl/uart_cmd_rx_if.sv
// ---------------------------------------------------------------------------
// uart_cmd_rx_if
// Read-side bundle of the uart command receiver.
//   read_data  - received word {high byte, low byte}
//   read_vld   - read_data holds an unconsumed word
//   read_rdy   - consumer accepts the word
//   parity_err - 1-cycle pulse, frame failed odd parity
//   frame_err  - 1-cycle pulse, stop bit sampled low
//   overrun    - 1-cycle pulse, completed word dropped
// Handshake: a word transfers on every clock edge where read_vld && read_rdy.
// Once read_vld is high, read_data is stable until that transfer happens;
// read_vld never drops without a transfer (except by reset).
// ---------------------------------------------------------------------------
interface uart_cmd_rx_if;
    logic [15:0] read_data;
    logic        read_vld;
    logic        read_rdy;
    logic        parity_err;
    logic        frame_err;
    logic        overrun;

    modport master (
        output read_data, read_vld, parity_err, frame_err, overrun,
        input  read_rdy
    );

    modport slave (
        input  read_data, read_vld, parity_err, frame_err, overrun,
        output read_rdy
    );
endinterface

// File: rtl/uart_rx_byte.sv
// ---------------------------------------------------------------------------
// uart_rx_byte
// Synchronises the serial line and decodes one frame:
// start(0), 8 data bits MSB-first, odd parity, stop(1).
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   rx          - asynchronous serial input, idle high
//   data_byte   - received byte, meaningful while byte_vld is high
//   byte_vld    - 1-cycle pulse, good frame received
//   parity_err  - 1-cycle pulse, parity check failed
//   frame_err   - 1-cycle pulse, stop bit sampled low
//   state_dbg   - current frame FSM state
// All three pulses come from the stop-bit sample cycle, so at most one of
// them is high at a time.
// ---------------------------------------------------------------------------
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_byte,
    output logic                 byte_vld,
    output logic                 parity_err,
    output logic                 frame_err,
    output rx_state_e            state_dbg
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;

    rx_state_e              state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [2:0]             bit_q, bit_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic                   par_q, par_d;

    // Flops reset to 1 so a reset does not look like a start bit.
    always_ff @(posedge clk) begin
        if (!rst_n) sync_q <= '1;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
    end

    assign rxs = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        par_d      = par_q;
        byte_vld   = 1'b0;
        parity_err = 1'b0;
        frame_err  = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rxs) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            // Half a bit in, re-check the start bit; a high here was a glitch.
            START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    bit_d = '0;
                    state_d = rxs ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            // From mid-start, one full period lands on mid-bit of each field.
            DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shreg_d = {shreg_q[DATA_BITS-2:0], rxs};
                    if (bit_q == LAST_BIT) state_d = PARITY;
                    else                   bit_d = bit_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PARITY: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    par_d   = rxs;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (!rxs) begin
                        frame_err = 1'b1;
                        state_d   = BREAK;
                    end else if (par_q != odd_par(shreg_q)) begin
                        parity_err = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        byte_vld = 1'b1;
                        state_d  = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            // Line held low: wait for it to return high before hunting again.
            BREAK: begin
                if (rxs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign data_byte = shreg_q;
    assign state_dbg = state_q;

endmodule

// File: rtl/uart_cmd_rx.sv
// ---------------------------------------------------------------------------
// uart_cmd_rx
// Receives the two-frame command stream (high byte first) and presents
// 16-bit words on a valid/ready handshake.
// Ports:
//   clk, rst_n - clock, synchronous active-low reset
//   rx         - asynchronous serial input, idle high
//   bus        - read-side bundle (uart_cmd_rx_if.master): read_data,
//                read_vld, read_rdy, parity_err, frame_err, overrun
// A word completes on the stop sample of the low frame; read_vld rises on
// the next edge. A completion while a word waits unaccepted is dropped and
// flagged with overrun. Any frame error restarts pairing at the high byte.
// ---------------------------------------------------------------------------
module uart_cmd_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         rx,
    uart_cmd_rx_if.master bus
);

    logic [DATA_BITS-1:0] rx_byte;
    logic                 rx_vld;
    logic                 rx_perr;
    logic                 rx_ferr;
    rx_state_e            rx_state;

    byte_idx_e            idx_q;
    logic [DATA_BITS-1:0] high_q;
    logic [15:0]          read_data_q;
    logic                 read_vld_q;
    logic                 parity_err_q;
    logic                 frame_err_q;
    logic                 overrun_q;
    logic                 word_done;

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .SYNC_STAGES  (SYNC_STAGES)
    ) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .data_byte  (rx_byte),
        .byte_vld   (rx_vld),
        .parity_err (rx_perr),
        .frame_err  (rx_ferr),
        .state_dbg  (rx_state)
    );

    assign word_done = rx_vld && (idx_q == IDX_LOW);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q        <= IDX_HIGH;
            high_q       <= '0;
            read_data_q  <= '0;
            read_vld_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            parity_err_q <= rx_perr;
            frame_err_q  <= rx_ferr;
            overrun_q    <= 1'b0;

            // Pairing: an error throws away any held high byte.
            if (rx_perr || rx_ferr) begin
                idx_q <= IDX_HIGH;
            end else if (rx_vld) begin
                if (idx_q == IDX_HIGH) begin
                    high_q <= rx_byte;
                    idx_q  <= IDX_LOW;
                end else begin
                    idx_q <= IDX_HIGH;
                end
            end

            // Output slot: load when empty or being drained this cycle,
            // otherwise the new word is lost.
            if (word_done) begin
                if (!read_vld_q || bus.read_rdy) begin
                    read_data_q <= {high_q, rx_byte};
                    read_vld_q  <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (read_vld_q && bus.read_rdy) begin
                read_vld_q <= 1'b0;
            end
        end
    end

    assign bus.read_data  = read_data_q;
    assign bus.read_vld   = read_vld_q;
    assign bus.parity_err = parity_err_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_cmd_rx
// Directed bench for uart_cmd_rx with CLKS_PER_BIT=4. Frames are driven
// bit by bit, a negedge monitor records delivered words and pulse cycles,
// and each step checks against hand-computed values.
// ---------------------------------------------------------------------------
module tb_uart_cmd_rx;
    import uart_pkg::*;

    localparam int CPB = 4;

    logic clk;
    logic rst_n;
    logic rx;

    uart_cmd_rx_if bus ();

    uart_cmd_rx #(
        .CLKS_PER_BIT (CPB),
        .SYNC_STAGES  (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rx    (rx),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- monitor ----------------
    logic [15:0] got_q[$];
    logic [15:0] exp_q[$];
    int vld_cyc, perr_cyc, ferr_cyc, ovr_cyc;
    logic vld_prev;

    initial begin
        vld_cyc = 0; perr_cyc = 0; ferr_cyc = 0; ovr_cyc = 0; vld_prev = 1'b0;
    end

    always @(negedge clk) begin
        if (bus.read_vld && !vld_prev) got_q.push_back(bus.read_data);
        vld_prev = bus.read_vld;
        if (bus.read_vld)   vld_cyc  = vld_cyc + 1;
        if (bus.parity_err) perr_cyc = perr_cyc + 1;
        if (bus.frame_err)  ferr_cyc = ferr_cyc + 1;
        if (bus.overrun)    ovr_cyc  = ovr_cyc + 1;
    end

    // ---------------- checking ----------------
    int checks;
    int errors;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_words(input string tag);
        logic [15:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (got_q.size() == 0) begin
                check(tag, 32'hdead_0000, {16'h0, e});
            end else begin
                check(tag, {16'h0, got_q.pop_front()}, {16'h0, e});
            end
        end
        check({tag, "_extra"}, got_q.size(), 0);
        got_q.delete();
    endtask

    // ---------------- drivers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        tick(CPB);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic stop);
        drive_bit(1'b0);
        for (int i = 7; i >= 0; i--) drive_bit(d[i]);
        drive_bit(p);
        drive_bit(stop);
        rx = 1'b1;
    endtask

    int v0, p0, f0, o0;

    task automatic snap();
        v0 = vld_cyc; p0 = perr_cyc; f0 = ferr_cyc; o0 = ovr_cyc;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        checks = 0;
        errors = 0;
        rx = 1'b1;
        rst_n = 1'b0;
        bus.read_rdy = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(1);

        // reset state
        check("rst_vld", bus.read_vld, 0);
        check("rst_data", bus.read_data, 0);
        check("rst_perr", bus.parity_err, 0);
        check("rst_ferr", bus.frame_err, 0);
        check("rst_ovr", bus.overrun, 0);
        check("rst_state", dut.rx_state, IDLE);

        // A5 / 5A, consumer always ready
        snap();
        send_frame(8'hA5, 1'b1, 1'b1);
        send_frame(8'h5A, 1'b1, 1'b1);
        tick(10);
        exp_q.push_back(16'hA55A);
        check_words("word_a55a");
        check("a55a_vld_cycles", vld_cyc - v0, 1);
        check("a55a_perr", perr_cyc - p0, 0);
        check("a55a_ferr", ferr_cyc - f0, 0);
        check("a55a_ovr", ovr_cyc - o0, 0);
        check("a55a_vld_low", bus.read_vld, 0);

        // 00 / 01
        send_frame(8'h00, 1'b1, 1'b1);
        send_frame(8'h01, 1'b0, 1'b1);
        tick(10);
        exp_q.push_back(16'h0001);
        check_words("word_0001");

        // parity error on 0x12 resets pairing, then 34 / 56
        snap();
        send_frame(8'h12, 1'b0, 1'b1);
        tick(6);
        check("perr_pulse", perr_cyc - p0, 1);
        check("perr_no_word", got_q.size(), 0);
        send_frame(8'h34, 1'b0, 1'b1);
        send_frame(8'h56, 1'b1, 1'b1);
        tick(10);
        exp_q.push_back(16'h3456);
        check_words("word_3456");
        check("perr_only_once", perr_cyc - p0, 1);

        // stop bit low, line held low for 3 bit times, then BE / EF
        snap();
        send_frame(8'h77, 1'b1, 1'b0);
        rx = 1'b0;
        tick(3 * CPB);
        check("break_state", dut.rx_state, BREAK);
        check("ferr_pulse", ferr_cyc - f0, 1);
        rx = 1'b1;
        tick(2 * CPB);
        check("break_exit", dut.rx_state, IDLE);
        send_frame(8'hBE, 1'b1, 1'b1);
        send_frame(8'hEF, 1'b0, 1'b1);
        tick(10);
        exp_q.push_back(16'hBEEF);
        check_words("word_beef");
        check("ferr_only_once", ferr_cyc - f0, 1);
        check("beef_perr", perr_cyc - p0, 0);

        // consumer stalled: second word is an overrun
        snap();
        bus.read_rdy = 1'b0;
        send_frame(8'h11, 1'b1, 1'b1);
        send_frame(8'h11, 1'b1, 1'b1);
        tick(10);
        check("stall_vld", bus.read_vld, 1);
        check("stall_data", bus.read_data, 16'h1111);
        send_frame(8'h22, 1'b1, 1'b1);
        send_frame(8'h22, 1'b1, 1'b1);
        tick(10);
        check("ovr_pulse", ovr_cyc - o0, 1);
        check("ovr_vld_held", bus.read_vld, 1);
        check("ovr_data_held", bus.read_data, 16'h1111);
        bus.read_rdy = 1'b1;
        tick(1);
        check("drain_vld", bus.read_vld, 0);
        check("drain_data_held", bus.read_data, 16'h1111);
        exp_q.push_back(16'h1111);
        check_words("word_1111");

        // 1-clk low glitch while idle
        snap();
        rx = 1'b0;
        tick(1);
        rx = 1'b1;
        tick(20);
        check("glitch_state", dut.rx_state, IDLE);
        check("glitch_vld", vld_cyc - v0, 0);
        check("glitch_errs", (perr_cyc - p0) + (ferr_cyc - f0) + (ovr_cyc - o0), 0);
        check("glitch_data", bus.read_data, 16'h1111);
        check("glitch_no_word", got_q.size(), 0);

        // reset in the middle of the second byte's data bits
        send_frame(8'hC3, 1'b1, 1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        check("mid_data_state", dut.rx_state, DATA);
        rst_n = 1'b0;
        tick(1);
        check("mid_rst_vld", bus.read_vld, 0);
        check("mid_rst_data", bus.read_data, 0);
        check("mid_rst_state", dut.rx_state, IDLE);
        check("mid_rst_pulses", {bus.parity_err, bus.frame_err, bus.overrun}, 0);
        rst_n = 1'b1;
        rx = 1'b1;
        tick(3 * CPB);
        got_q.delete();
        send_frame(8'h9C, 1'b1, 1'b1);
        send_frame(8'h3D, 1'b0, 1'b1);
        tick(10);
        exp_q.push_back(16'h9C3D);
        check_words("word_9c3d");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
